iir_biquad_cascade: RTL and testbench
=====================================

// Module: iir_biquad_cascade
// PURPOSE
//  Time-multiplexed cascade of N_SECT second-order IIR sections with one shared signed multiplier-accumulator.
//  Coefficients are held in an internal register file. Each section keeps its own delay-line state.
//  Samples enter and leave through valid/ready handshakes. Sits between the sample source and the output stage.
// PARAMETERS
//  DWIDTH  16  sample width, signed two's complement
//  CWIDTH  24  coefficient width, signed, Q3.(CWIDTH-3): 1.0 = 1<<(CWIDTH-3)
//  N_SECT  2   number of cascaded biquad sections, 1..8
// PORTS
//  clk          in   1                    clock, rising edge
//  rst_n        in   1                    asynchronous reset, active low
//  in_valid     in   1                    x_in is valid
//  in_ready     out  1                    block can accept a sample
//  x_in         in   DWIDTH               input sample
//  out_valid    out  1                    y_out is valid
//  out_ready    in   1                    downstream accepts y_out
//  y_out        out  DWIDTH               filtered sample (last section output)
//  coef_we      in   1                    coefficient write strobe
//  coef_addr    in   $clog2(N_SECT*5)     sect*5+idx; idx 0..4 = b0,b1,b2,a1,a2
//  coef_wdata   in   CWIDTH               coefficient value
//  coef_err     out  1                    one-cycle pulse: write rejected (busy or addr >= N_SECT*5)
//  clear_state  in   1                    zero all delay lines (acted on in IDLE only)
// BEHAVIOUR
//  Reset (async assert, sync release) clears all coefficients, all delay lines and the accumulator.
//  Reset values: in_ready=1, out_valid=0, y_out=0, coef_err=0. FSM goes to IDLE.
//  Per section: y = b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2. The a-coefficients are stored pre-negated, so every term is added.
//  FSM states: IDLE -> MAC -> STORE -> (MAC for the next section | OUT) -> IDLE.
//   IDLE:  in_ready=1. On in_valid&in_ready, latch x_in as the section-0 input and go to MAC, with sect=0 and tap=0.
//   MAC:   5 cycles per section, one product per cycle, in order tap 0..4.
//          On tap 0 the accumulator is loaded with the product. Otherwise the product is added.
//   STORE: saturate and round the accumulator to DWIDTH bits.
//          Shift the section's history: x2<=x1, x1<=x0, y2<=y1, y1<=result. The result becomes the input of section sect+1.
//          If sect==N_SECT-1, go to OUT with y_out=result. Otherwise go to MAC with sect+1.
//   OUT:   out_valid=1. y_out holds stable until out_valid&out_ready, then return to IDLE.
//  in_ready=0 in every state except IDLE. No input is accepted while a sample is in flight or held.
//  Latency: out_valid rises 6*N_SECT+1 cycles after the accepting edge. Throughput is 1 sample per 6*N_SECT+2 cycles when out_ready=1.
//  Arithmetic:
//   - Products are DWIDTH+CWIDTH bits. The accumulator is DWIDTH+CWIDTH+3 bits, signed, and cannot overflow over 5 terms.
//   - Saturate the accumulator to DWIDTH+CWIDTH-3 signed bits.
//   - Round half-up: add 1<<(CWIDTH-4), then drop the CWIDTH-3 LSBs.
//   - Clamp to +max if the rounding add overflows positive.
//  Coefficient writes:
//   - Applied in IDLE only, and take effect for the next accepted sample.
//   - coef_we outside IDLE, or with an out-of-range address, writes nothing and pulses coef_err on the next cycle.
//  clear_state:
//   - In IDLE: zeroes all delay lines in 1 cycle.
//   - If in_valid is also high that cycle, the clear wins and the sample is not accepted (in_ready forced 0 that cycle).
//   - Ignored outside IDLE.
//  Reset mid-operation aborts the sample: no out_valid, state zeroed.
// CONFIGURATION
//  IIR_OVF_FLAG_EN
//   - Defined: adds output port ovf_sticky (1 bit, reset 0).
//     It is set in STORE when either the saturation stage or the rounding clamp engages in any section.
//     It is cleared only by reset or by an accepted clear_state.
//   - Undefined: the port and its logic are absent, and saturation is silent.
// TESTING
//  1 Reset: assert rst_n=0 mid-sample -> out_valid=0, in_ready=1, y_out=0 immediately. A later sample with zero coefs gives y_out=0.
//  2 Passthrough, N_SECT=2, b0=0x200000, others 0: x_in=0x1234 -> y_out=0x1234, out_valid exactly 13 cycles after accept.
//  3 Impulse, N_SECT=1, b0=0x200000, a1=0x100000: inputs 0x4000,0,0,0 -> outputs 0x4000,0x2000,0x1000,0x0800.
//  4 Saturation, b0=0x7FFFFF: x_in=0x7FFF -> 0x7FFF, and x_in=0x8000 -> 0x8000. With IIR_OVF_FLAG_EN, ovf_sticky=1 and stays 1.
//  5 Backpressure: out_ready=0 for 10 cycles -> y_out stable, in_ready=0, and in_valid pulses are not accepted. out_ready=1 -> IDLE next cycle.
//  6 Coef write while busy -> coef_err pulse and the old coefficient stays in use. clear_state in IDLE -> next impulse response restarts from zero history.

Source files
------------

// File: rtl/iir_biquad_cascade_if.sv
// iir_biquad_cascade_if: sample handshake, coefficient write port and state-clear bundle for the biquad cascade
interface iir_biquad_cascade_if #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 24,
    parameter int N_SECT = 2
);
    localparam int AW = $clog2(N_SECT * 5);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] x_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] y_out;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [CWIDTH-1:0] coef_wdata;
    logic                     coef_err;
    logic                     clear_state;
    modport master (
        output in_valid, x_in, out_ready, coef_we, coef_addr, coef_wdata, clear_state,
        input  in_ready, out_valid, y_out, coef_err
    );
    modport slave (
        input  in_valid, x_in, out_ready, coef_we, coef_addr, coef_wdata, clear_state,
        output in_ready, out_valid, y_out, coef_err
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: time-multiplexed N_SECT biquad cascade sharing one MAC.
// Optional IIR_OVF_FLAG_EN adds a sticky saturation flag port ovf_sticky.
module iir_biquad_cascade #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 24,
    parameter int N_SECT = 2
) (
    input logic clk,
    input logic rst_n,
    iir_biquad_cascade_if.slave bus
`ifdef IIR_OVF_FLAG_EN
    ,
    output logic ovf_sticky
`endif
);
    localparam int AW   = $clog2(N_SECT * 5);
    localparam int SW   = N_SECT > 1 ? $clog2(N_SECT) : 1;
    localparam int PW   = DWIDTH + CWIDTH;
    localparam int ACCW = PW + 3;
    localparam int SATW = PW - 3;

    typedef enum logic [1:0] {IDLE, MAC, STORE, OUT} state_t;
    state_t state, state_nxt;

    logic signed [CWIDTH-1:0] coef [N_SECT][5];
    logic signed [DWIDTH-1:0] x1 [N_SECT];
    logic signed [DWIDTH-1:0] x2 [N_SECT];
    logic signed [DWIDTH-1:0] y1 [N_SECT];
    logic signed [DWIDTH-1:0] y2 [N_SECT];
    logic signed [DWIDTH-1:0] cur_x, opnd, res;
    logic signed [CWIDTH-1:0] cval;
    logic signed [PW-1:0]     prod;
    logic signed [ACCW-1:0]   acc;
    logic [DWIDTH:0]          sat, rnd;
    logic [SW-1:0]            sect;
    logic [2:0]               tap;
    logic accept, addr_ok, last, sat_hit, rnd_hit, idle_clr, unused_lsb;

    assign accept       = state == IDLE && bus.in_valid && !bus.clear_state;
    assign idle_clr     = state == IDLE && bus.clear_state;
    assign bus.in_ready = state == IDLE && !bus.clear_state;
    assign bus.out_valid = state == OUT;
    assign addr_ok      = {1'b0, bus.coef_addr} < (AW + 1)'(N_SECT * 5);
    assign last         = sect == SW'(N_SECT - 1);

    assign opnd = tap == 3'd0 ? cur_x :
                  tap == 3'd1 ? x1[sect] :
                  tap == 3'd2 ? x2[sect] :
                  tap == 3'd3 ? y1[sect] : y2[sect];
    assign cval = coef[sect][tap];
    assign prod = opnd * cval;

    // Keep only the DWIDTH+1 bits above the dropped fraction; bit 0 is the half-LSB used for rounding.
    assign sat_hit = !(&acc[ACCW-1:SATW-1] || ~|acc[ACCW-1:SATW-1]);
    assign sat     = sat_hit ? {acc[ACCW-1], {DWIDTH{~acc[ACCW-1]}}} : acc[SATW-1:CWIDTH-4];
    assign rnd     = {sat[DWIDTH], sat[DWIDTH:1]} + (DWIDTH + 1)'(sat[0]);
    assign rnd_hit = rnd[DWIDTH] != rnd[DWIDTH-1];
    assign res     = rnd_hit ? {1'b0, {(DWIDTH - 1){1'b1}}} : rnd[DWIDTH-1:0];
    assign unused_lsb = ^acc[CWIDTH-5:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? MAC : IDLE;
            MAC:     state_nxt = tap == 3'd4 ? STORE : MAC;
            STORE:   state_nxt = last ? OUT : MAC;
            default: state_nxt = bus.out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SECT; s++) begin
                for (int i = 0; i < 5; i++) coef[s][i] <= '0;
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
            cur_x        <= '0;
            acc          <= '0;
            sect         <= '0;
            tap          <= '0;
            bus.y_out    <= '0;
            bus.coef_err <= 1'b0;
        end else begin
            bus.coef_err <= bus.coef_we && (state != IDLE || !addr_ok);
            if (bus.coef_we && state == IDLE && addr_ok)
                for (int s = 0; s < N_SECT; s++)
                    for (int i = 0; i < 5; i++)
                        if (bus.coef_addr == AW'(s * 5 + i)) coef[s][i] <= bus.coef_wdata;
            if (idle_clr)
                for (int s = 0; s < N_SECT; s++) begin
                    x1[s] <= '0;
                    x2[s] <= '0;
                    y1[s] <= '0;
                    y2[s] <= '0;
                end
            if (accept) begin
                cur_x <= bus.x_in;
                sect  <= '0;
                tap   <= '0;
            end
            if (state == MAC) begin
                acc <= tap == 3'd0 ? ACCW'(prod) : acc + ACCW'(prod);
                tap <= tap == 3'd4 ? 3'd0 : tap + 3'd1;
            end
            if (state == STORE) begin
                x2[sect] <= x1[sect];
                x1[sect] <= cur_x;
                y2[sect] <= y1[sect];
                y1[sect] <= res;
                cur_x    <= res;
                sect     <= sect + SW'(1);
                if (last) bus.y_out <= res;
            end
        end
    end

`ifdef IIR_OVF_FLAG_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_sticky <= 1'b0;
        else if (idle_clr) ovf_sticky <= 1'b0;
        else if (state == STORE && (sat_hit || rnd_hit)) ovf_sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: directed self-checking bench for the biquad cascade (N_SECT=2).
module tb_iir_biquad_cascade;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int lat = 0;

    iir_biquad_cascade_if #(.DWIDTH(16), .CWIDTH(24), .N_SECT(2)) bus ();
`ifdef IIR_OVF_FLAG_EN
    logic ovf;
`endif

    iir_biquad_cascade #(.DWIDTH(16), .CWIDTH(24), .N_SECT(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef IIR_OVF_FLAG_EN
        ,
        .ovf_sticky(ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        bus.coef_we = 1'b1;
        bus.coef_addr = a;
        bus.coef_wdata = d;
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        bus.clear_state = 1'b1;
        @(negedge clk);
        bus.clear_state = 1'b0;
    endtask

    // n0 = rising edges already elapsed since (and including) the accepting edge
    task automatic wait_out(input int n0);
        int n = n0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = n;
    endtask

    task automatic sample(input logic [15:0] x, input logic [15:0] exp, input string tag);
        @(negedge clk);
        bus.x_in = x;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(1);
        check({tag, "_lat"}, 32'(lat), 32'd13);
        check(tag, 32'({bus.y_out}), 32'(exp));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.x_in = '0;
        bus.out_ready = 1'b1;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_wdata = '0;
        bus.clear_state = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y_out", 32'({bus.y_out}), 32'h0);
        check("rst_coef_err", 32'(bus.coef_err), 32'd0);

        wr(4'd0, 24'h200000);
        wr(4'd5, 24'h200000);
        sample(16'h1234, 16'h1234, "pass");

        // reset in the middle of a sample
        @(negedge clk);
        bus.x_in = 16'h1111;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_y_out", 32'({bus.y_out}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sample(16'h5555, 16'h0000, "zero_coef");

        // impulse: section 0 b0=1.0 a1=0.5, section 1 passthrough
        wr(4'd0, 24'h200000);
        wr(4'd3, 24'h100000);
        wr(4'd5, 24'h200000);
        sample(16'h4000, 16'h4000, "imp0");
        sample(16'h0000, 16'h2000, "imp1");
        sample(16'h0000, 16'h1000, "imp2");
        sample(16'h0000, 16'h0800, "imp3");

        // saturation
        clr();
        wr(4'd3, 24'h000000);
        wr(4'd0, 24'h7FFFFF);
        sample(16'h7FFF, 16'h7FFF, "sat_pos");
        sample(16'h8000, 16'h8000, "sat_neg");
`ifdef IIR_OVF_FLAG_EN
        check("ovf_set", 32'(ovf), 32'd1);
`endif

        // backpressure
        wr(4'd0, 24'h200000);
        bus.out_ready = 1'b0;
        sample(16'h0ABC, 16'h0ABC, "bp");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.x_in = 16'h7777;
            #1;
            check("bp_y_hold", 32'({bus.y_out}), 32'h0ABC);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_no_accept", 32'(bus.out_valid), 32'd0);
`ifdef IIR_OVF_FLAG_EN
        check("ovf_sticks", 32'(ovf), 32'd1);
`endif

        // coefficient write while busy is rejected
        @(negedge clk);
        bus.x_in = 16'h0100;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.coef_we = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_wdata = 24'h100000;
        @(negedge clk);
        check("busy_err_pulse", 32'(bus.coef_err), 32'd1);
        bus.coef_we = 1'b0;
        @(negedge clk);
        check("busy_err_end", 32'(bus.coef_err), 32'd0);
        wait_out(3);
        check("busy_lat", 32'(lat), 32'd13);
        check("busy_y", 32'({bus.y_out}), 32'h0100);
        sample(16'h0200, 16'h0200, "old_coef");
        wr(4'd12, 24'h123456);
        check("range_err", 32'(bus.coef_err), 32'd1);
        wr(4'd0, 24'h200000);
        check("good_wr_err", 32'(bus.coef_err), 32'd0);

        // clear_state
        clr();
`ifdef IIR_OVF_FLAG_EN
        check("ovf_cleared", 32'(ovf), 32'd0);
`endif
        wr(4'd3, 24'h100000);
        sample(16'h4000, 16'h4000, "clr_imp0");
        sample(16'h0000, 16'h2000, "clr_imp1");
        @(negedge clk);
        bus.clear_state = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in = 16'h4000;
        #1;
        check("clr_blocks_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.clear_state = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_no_accept", 32'(bus.out_valid), 32'd0);
        check("clr_idle_ready", 32'(bus.in_ready), 32'd1);
        sample(16'h0000, 16'h0000, "clr_hist0");
        sample(16'h4000, 16'h4000, "clr_imp2");
        sample(16'h0000, 16'h2000, "clr_imp3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
